// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART definitions: transmitter state encoding, parity helper
//           and parameter legality checks.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  localparam logic [2:0] c_LAST_DATA_BIT = 3'd7;

  // Even parity is the XOR of the byte; odd parity is its complement.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic bit stop_bits_legal(input int n);
    return (n == 1) || (n == 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Brief   : UART transmitter, LSB first, optional parity, 1 or 2 stop bits,
//           one-deep holding register for gapless back-to-back frames.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter logic ParityEn  = 1'b0,
  parameter logic ParityOdd = 1'b0,
  parameter int   StopBits  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_strobe,
  output logic       o_prescaler_en,
  output logic       o_tx,
  output logic       o_busy
);

  generate
    if (!stop_bits_legal(StopBits)) begin : g_bad_stop_bits
      $error("uart_tx: StopBits must be 1 or 2");
    end
  endgenerate

  localparam logic c_LAST_STOP = (StopBits == 2) ? 1'b1 : 1'b0;

  tx_state_e  r_state;
  logic       r_tx;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;
  logic       r_parity;
  logic [7:0] r_hold;
  logic       r_hold_full;

  tx_state_e  w_state_nxt;
  logic       w_tx_nxt;
  logic [7:0] w_shift_nxt;
  logic [2:0] w_bit_cnt_nxt;
  logic       w_stop_cnt_nxt;
  logic       w_parity_nxt;
  logic       w_load;
  logic       w_accept;

  assign w_accept = i_valid && !r_hold_full;

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_nxt       = r_tx;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_parity_nxt   = r_parity;
    w_load         = 1'b0;

    case (r_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        w_load   = r_hold_full;
      end
      TX_START: begin
        if (i_strobe) begin
          w_state_nxt   = TX_DATA;
          w_tx_nxt      = r_shift[0];
          w_bit_cnt_nxt = 3'd0;
        end
      end
      TX_DATA: begin
        if (i_strobe) begin
          if (r_bit_cnt == c_LAST_DATA_BIT) begin
            if (ParityEn) begin
              w_state_nxt = TX_PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt    = TX_STOP;
              w_tx_nxt       = 1'b1;
              w_stop_cnt_nxt = 1'b0;
            end
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (i_strobe) begin
          w_state_nxt    = TX_STOP;
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      TX_STOP: begin
        if (i_strobe) begin
          if (r_stop_cnt == c_LAST_STOP) begin
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = TX_IDLE;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Parity is latched from the byte as loaded, before any shifting.
    if (w_load) begin
      w_state_nxt    = TX_START;
      w_tx_nxt       = 1'b0;
      w_shift_nxt    = r_hold;
      w_parity_nxt   = parity_bit(r_hold, ParityOdd);
      w_bit_cnt_nxt  = 3'd0;
      w_stop_cnt_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= TX_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx       <= w_tx_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_parity   <= w_parity_nxt;
    end
  end

  // A new accept wins over a same-edge load so the fresh byte is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= i_tx_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  assign o_ready        = !r_hold_full;
  assign o_busy         = (r_state != TX_IDLE);
  assign o_prescaler_en = (r_state != TX_IDLE);
  assign o_tx           = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx
// Brief   : Directed bench for uart_tx in four parameter configurations,
//           with a bench-side prescaler model supplying the bit strobes.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int N = 8;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic [3:0] valid;
  logic [3:0] force_strobe;
  wire  [3:0] strobe;
  wire  [3:0] ready;
  wire  [3:0] pen;
  wire  [3:0] tx;
  wire  [3:0] busy;
  logic [3:0] pcnt [4];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_presc
    always @(posedge clk) begin
      if (!pen[g] || pcnt[g] == 4'(N - 1)) pcnt[g] <= 4'd0;
      else                                 pcnt[g] <= pcnt[g] + 4'd1;
    end
    assign strobe[g] = (pen[g] && pcnt[g] == 4'(N - 1)) || force_strobe[g];
  end

  uart_tx #(.ParityEn(1'b0), .ParityOdd(1'b0), .StopBits(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_valid(valid[0]), .o_ready(ready[0]),
    .i_strobe(strobe[0]), .o_prescaler_en(pen[0]), .o_tx(tx[0]), .o_busy(busy[0]));
  uart_tx #(.ParityEn(1'b1), .ParityOdd(1'b0), .StopBits(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_valid(valid[1]), .o_ready(ready[1]),
    .i_strobe(strobe[1]), .o_prescaler_en(pen[1]), .o_tx(tx[1]), .o_busy(busy[1]));
  uart_tx #(.ParityEn(1'b1), .ParityOdd(1'b1), .StopBits(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_valid(valid[2]), .o_ready(ready[2]),
    .i_strobe(strobe[2]), .o_prescaler_en(pen[2]), .o_tx(tx[2]), .o_busy(busy[2]));
  uart_tx #(.ParityEn(1'b0), .ParityOdd(1'b0), .StopBits(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_valid(valid[3]), .o_ready(ready[3]),
    .i_strobe(strobe[3]), .o_prescaler_en(pen[3]), .o_tx(tx[3]), .o_busy(busy[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Present a byte and hold it until accepted; returns cycles spent waiting on ready.
  task automatic send(input int d, input logic [7:0] b, input bit force_load, output int waited);
    waited = 0;
    @(negedge clk);
    data     = b;
    valid[d] = 1'b1;
    while (ready[d] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (ready[d] !== 1'b1) begin
      timeout($sformatf("send%0d_ready", d));
      valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    valid[d] = 1'b0;
    if (force_load) begin
      force_strobe[d] = 1'b1;
      @(negedge clk);
      force_strobe[d] = 1'b0;
    end
  endtask

  // Waits for the start bit then samples each bit mid-period; exp bit k = k-th bit on the line.
  task automatic check_frame(input int d, input logic [31:0] exp, input int nbits, input string name);
    int waited = 0;
    @(negedge clk);
    while (tx[d] !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (tx[d] !== 1'b0) begin
      timeout({name, "_start"});
      return;
    end
    repeat (N / 2) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) repeat (N) @(negedge clk);
      chk($sformatf("%s_bit%0d", name, k), {31'd0, tx[d]}, {31'd0, exp[k]});
    end
    repeat (N / 2 - 1) @(negedge clk);
    chk({name, "_busy_last"}, {31'd0, busy[d]}, 32'd1);
    @(negedge clk);
    chk({name, "_busy_end"}, {31'd0, busy[d]}, 32'd0);
    chk({name, "_tx_idle"}, {31'd0, tx[d]}, 32'd1);
  endtask

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [31:0] frame;
    int          nbits;
    bit          force_load;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0] = '{0, 8'h55, 32'h2AA, 10, 1'b0};
    vecs[1] = '{1, 8'hA3, 32'h546, 11, 1'b0};
    vecs[2] = '{2, 8'hA3, 32'h746, 11, 1'b0};
    vecs[3] = '{3, 8'h80, 32'h700, 11, 1'b0};
    vecs[4] = '{0, 8'hFF, 32'h3FE, 10, 1'b1};
    vecs[5] = '{1, 8'h01, 32'h602, 11, 1'b0};
    vecs[6] = '{2, 8'h00, 32'h600, 11, 1'b0};
    vecs[7] = '{3, 8'hC5, 32'h78A, 11, 1'b1};
    vecs[8] = '{0, 8'h3C, 32'h278, 10, 1'b0};

    rst = 1'b1;
    data = 8'h00;
    valid = 4'h0;
    force_strobe = 4'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d_tx", d),    {31'd0, tx[d]},    32'd1);
      chk($sformatf("rst%0d_ready", d), {31'd0, ready[d]}, 32'd1);
      chk($sformatf("rst%0d_busy", d),  {31'd0, busy[d]},  32'd0);
      chk($sformatf("rst%0d_pen", d),   {31'd0, pen[d]},   32'd0);
    end
    rst = 1'b0;

    // Strobes while idle must not start anything.
    force_strobe[0] = 1'b1;
    repeat (5) @(negedge clk);
    force_strobe[0] = 1'b0;
    chk("idle_strobe_busy", {31'd0, busy[0]}, 32'd0);
    chk("idle_strobe_tx",   {31'd0, tx[0]},   32'd1);

    for (int i = 0; i < 9; i++) begin
      fork
        check_frame(vecs[i].dut, vecs[i].frame, vecs[i].nbits, $sformatf("vec%0d", i));
        send(vecs[i].dut, vecs[i].data, vecs[i].force_load, w);
      join
    end

    // Back-to-back 0x00 then 0xFF with valid held high throughout.
    fork
      check_frame(0, 32'hFFA00, 20, "b2b");
      begin
        int t;
        @(negedge clk);
        data = 8'h00;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready0", {31'd0, ready[0]}, 32'd0);
        data = 8'hFF;
        t = 0;
        while (ready[0] !== 1'b1 && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (ready[0] !== 1'b1) timeout("b2b_ready_rise");
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready1", {31'd0, ready[0]}, 32'd0);
        valid[0] = 1'b0;
      end
    join

    // Two stop bits; second byte offered mid-frame follows only after both stops.
    fork
      check_frame(3, 32'h3C5700, 22, "stop2");
      begin
        send(3, 8'h80, 1'b0, w);
        repeat (30) @(negedge clk);
        send(3, 8'hC5, 1'b0, w);
      end
    join

    // Valid held against a full holding register; the held byte must survive.
    fork
      check_frame(0, 32'h332AD278, 30, "hold");
      begin
        send(0, 8'h3C, 1'b0, w);
        send(0, 8'h5A, 1'b0, w);
        send(0, 8'h99, 1'b0, w);
        chk("hold_wait_ge50", {31'd0, (w >= 50)}, 32'd1);
      end
    join

    // Reset in the middle of data bit 4, with a byte waiting in the holding register.
    send(0, 8'h3C, 1'b0, w);
    send(0, 8'h77, 1'b0, w);
    repeat (5 * N + N / 2 - 1) @(negedge clk);
    chk("pre_rst_busy",  {31'd0, busy[0]},  32'd1);
    chk("pre_rst_ready", {31'd0, ready[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx",    {31'd0, tx[0]},    32'd1);
    chk("mid_rst_ready", {31'd0, ready[0]}, 32'd1);
    chk("mid_rst_pen",   {31'd0, pen[0]},   32'd0);
    chk("mid_rst_busy",  {31'd0, busy[0]},  32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy[0]}, 32'd0);
    fork
      check_frame(0, 32'h278, 10, "post_rst");
      send(0, 8'h3C, 1'b0, w);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
